// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: fetch state encoding, instruction size and queue entry layout
package fetch_unit_pkg;
  typedef enum logic [1:0] {FETCH, DRAIN, HALT} fetch_state_e;
  localparam int INSTR_BYTES = 4;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } q_entry_t;
endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// sync_fifo: flushable FIFO; push and pop in the same cycle both take effect even when full
module sync_fifo #(
  parameter int W = 32,
  parameter int D = 2,
  localparam int AW = D > 1 ? $clog2(D) : 1,
  localparam int CW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem_q [D];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full = cnt_q == CW'(D);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout = mem_q[rd_q];
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  always_comb begin
    wr_d = flush ? '0 : !do_push ? wr_q : wr_q == AW'(D - 1) ? '0 : wr_q + 1'b1;
    rd_d = flush ? '0 : !do_pop ? rd_q : rd_q == AW'(D - 1) ? '0 : rd_q + 1'b1;
    cnt_d = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // Storage needs no reset: readers qualify dout with empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with queue, redirect flush and stale-response drain.
// FETCH_MISALIGN_TRAP_EN: misaligned redirect targets halt fetch and raise sticky oMisalign.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        iClk,
  input  logic        iRstN,
  input  logic        iPCSrc,
  input  logic [31:0] iImmExt,
  input  logic [31:0] iBranchPC,
  output logic        oMemReq,
  output logic [31:0] oMemAddr,
  input  logic        iMemRvalid,
  input  logic [31:0] iMemRdata,
  output logic        oInstrValid,
  input  logic        iInstrReady,
  output logic [31:0] oInstr,
  output logic [31:0] oPC,
  output logic        oMisalign
);
  localparam int CW = $clog2(QDEPTH + 1);
  fetch_state_e state_q, state_d;
  logic [31:0] fpc_q, fpc_d, target, pf_pc;
  logic [CW-1:0] disc_q, disc_d, iq_cnt, pf_cnt;
  logic [CW:0] in_use;
  q_entry_t iq_head;
  logic iq_full, iq_empty, pf_full, pf_empty;
  logic pop, rsp_acc, rsp_push, misalign;
  logic unused_full;
  assign unused_full = &{1'b0, iq_full, pf_full};
  assign pop = !iq_empty && iInstrReady;
  // A slot freed by this cycle's pop is reusable immediately, sustaining one fetch per cycle.
  assign in_use = {1'b0, iq_cnt} + {1'b0, pf_cnt} - (CW + 1)'(pop);
  assign oMemReq = iRstN && state_q == FETCH && in_use < (CW + 1)'(QDEPTH);
  assign oMemAddr = fpc_q;
  assign rsp_acc = iMemRvalid && (disc_q != '0 || !pf_empty);
  assign rsp_push = iMemRvalid && disc_q == '0 && !pf_empty;
  assign oInstrValid = !iq_empty;
  assign oInstr = iq_empty ? '0 : iq_head.instr;
  assign oPC = iq_empty ? RESET_PC : iq_head.pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  assign target = iBranchPC + iImmExt;
  assign misalign = |target[1:0];
  assign oMisalign = misalign_q;
  always_comb misalign_d = iPCSrc ? misalign : misalign_q;
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) misalign_q <= 1'b0;
    else misalign_q <= misalign_d;
  end
`else
  assign target = (iBranchPC + iImmExt) & ~32'h3;
  assign misalign = 1'b0;
  assign oMisalign = 1'b0;
`endif
  // On redirect every request still in flight, including one issued now, becomes a discard.
  always_comb begin
    fpc_d = iPCSrc ? target : oMemReq ? fpc_q + 32'(INSTR_BYTES) : fpc_q;
    disc_d = iPCSrc ? disc_q + pf_cnt + CW'(oMemReq) - CW'(rsp_acc)
                    : disc_q - CW'(rsp_acc && disc_q != '0);
    state_d = iPCSrc ? (misalign ? HALT : disc_d != '0 ? DRAIN : FETCH)
                     : (state_q == DRAIN && disc_d == '0) ? FETCH : state_q;
  end
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= FETCH;
      fpc_q <= RESET_PC;
      disc_q <= '0;
    end else begin
      state_q <= state_d;
      fpc_q <= fpc_d;
      disc_q <= disc_d;
    end
  end
  sync_fifo #(.W($bits(q_entry_t)), .D(QDEPTH)) u_iq (
    .clk(iClk), .rst_n(iRstN), .flush(iPCSrc), .push(rsp_push),
    .din(q_entry_t'{pc: pf_pc, instr: iMemRdata}), .pop(pop), .dout(iq_head),
    .full(iq_full), .empty(iq_empty), .count(iq_cnt)
  );
  sync_fifo #(.W(32), .D(QDEPTH)) u_pf (
    .clk(iClk), .rst_n(iRstN), .flush(iPCSrc), .push(oMemReq),
    .din(fpc_q), .pop(rsp_push), .dout(pf_pc),
    .full(pf_full), .empty(pf_empty), .count(pf_cnt)
  );
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter QDEPTH, default 2: instruction queue entries; also the maximum outstanding memory requests.
REQ-003 iClk  input  1  sole clock, rising edge.
REQ-004 iRstN  input  1  asynchronous, active-low reset.
REQ-005 iPCSrc  input  1  redirect request from the control path (taken branch/jump).
REQ-006 iImmExt  input  32  sign-extended offset from the control path.
REQ-007 iBranchPC  input  32  PC of the redirecting instruction.
REQ-008 oMemReq  output  1  instruction memory read request.
REQ-009 oMemAddr  output  32  word-aligned read address.
REQ-010 iMemRvalid  input  1  read data valid, at least 1 cycle after the request.
REQ-011 iMemRdata  input  32  instruction word.
REQ-012 oInstrValid  output  1  queue head holds a valid instruction.
REQ-013 iInstrReady  input  1  consumer accepts the head.
REQ-014 oInstr  output  32  head instruction.
REQ-015 oPC  output  32  PC of the head instruction, fed to the control path as iPC.
REQ-016 oMisalign  output  1  misaligned-target flag (present only with the configuration macro).

Function
REQ-017 Fetch address register fpc: increments by 4 on each issued request.
REQ-018 Issue condition: oMemReq=1 iff state FETCH and (queue count + outstanding) < QDEPTH; oMemAddr=fpc.
REQ-019 Responses complete in order; each response is pushed with its PC, taken from a PC FIFO of outstanding requests.
REQ-020 Consumer handshake: the head pops when oInstrValid && iInstrReady; oInstr/oPC hold stable while oInstrValid && !iInstrReady.
REQ-021 Push and pop in the same cycle with the queue full: both take effect and count is unchanged.
REQ-022 Redirect: target = iBranchPC + iImmExt, modulo 2^32 (wrap-around allowed).
REQ-023 On iPCSrc=1 at an edge:
- queue flushes, so oInstrValid=0 next cycle;
- fpc <= target;
- discard counter <= outstanding requests, including any issued that cycle, minus any response accepted that cycle;
- state -> DRAIN if the discard counter is nonzero, else FETCH.
REQ-024 DRAIN: no requests issue; each iMemRvalid is dropped and decrements the discard counter; at zero, state -> FETCH.
REQ-025 Redirect during DRAIN: recompute the target and keep draining the remaining discards; the newest redirect wins.
REQ-026 Redirect and pop in the same cycle: the redirect dominates and no entry survives.
REQ-027 States: FETCH, DRAIN, HALT (HALT exists only with the macro).
REQ-028 iMemRvalid with no outstanding request: ignored.

Reset
REQ-029 While iRstN=0:
- oMemReq=0, oInstrValid=0, oInstr=0, oPC=RESET_PC, oMisalign=0;
- queue, PC FIFO, outstanding and discard counters cleared;
- fpc=RESET_PC; state FETCH.
REQ-030 Reset mid-operation abandons in-flight requests, and late responses are ignored per REQ-028.
REQ-031 First request issues on the first rising edge after iRstN deasserts.

Configuration
REQ-032 Macro FETCH_MISALIGN_TRAP_EN.
REQ-033 Defined: a redirect with target[1:0]!=0 flushes the queue, sets oMisalign=1 (sticky), enters HALT and issues no requests; the next redirect with an aligned target clears oMisalign and resumes via DRAIN/FETCH.
REQ-034 Undefined: target[1:0] is forced to 2'b00, oMisalign is tied 0, and HALT is absent.

Structure
REQ-035 Shared package holds:
- fetch state enum (FETCH, DRAIN, HALT);
- constant INSTR_BYTES=4;
- typedef for a queue entry {pc[31:0], instr[31:0]}.
REQ-036 Sub-module sync_fifo, parameterised width and depth, with push/pop/full/empty/count; it is instantiated for both the instruction queue and the PC FIFO.
REQ-037 Target adder and issue logic reside in fetch_unit.

Verification
REQ-038 Reset, then memory latency 1, iInstrReady=1 -> oPC sequence 0,4,8,C on consecutive cycles after fill; oMemReq continuous.
REQ-039 iInstrReady=0 for 5 cycles -> at most 2 requests issue, oMemReq drops, head stays PC 0; release -> 4,8 follow in order.
REQ-040 Latency 3, 2 requests outstanding, iPCSrc=1 with iBranchPC=8, iImmExt=-8 -> both responses dropped, next oPC=0, no stale instruction is presented.
REQ-041 iBranchPC=FFFF_FFFC, iImmExt=8 -> next fetch address 0000_0004.
REQ-042 Macro defined, target 0x102 -> oMisalign=1, oMemReq=0 for 10 cycles; redirect to 0x200 -> oMisalign=0, oPC=0x200.
REQ-043 iRstN pulsed low with 2 requests outstanding -> outputs at reset values; late iMemRvalid ignored; fetch restarts at RESET_PC.
